// File: rtl/decodificador_display.sv
// decodificador_display: receive side of the priority-code display link.
// Samples a 7-segment glyph {a,b,c,d,e,f,g}, waits until it has been stable
// for ESTAVEL_CICLOS consecutive samples, then decodes it into the 2-bit
// code {y1,y0} plus a one-hot copy and pulses ack for one cycle.
// Illegal glyphs set erro and keep the previous code.
// Optional macro CONTADOR_ERROS_EN builds the saturating illegal-glyph
// counter on cont_erros; without it cont_erros is tied to zero.
//
// Handshake: the sender holds valido high while the glyph is meaningful and
// must drop valido between codes; ack is a single-cycle pulse with y1/y0,
// saida, erro and cont_erros already updated in that same cycle.
module decodificador_display #(
    parameter int ESTAVEL_CICLOS = 4,
    parameter int CONT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seg_a,
    input  logic              seg_b,
    input  logic              seg_c,
    input  logic              seg_d,
    input  logic              seg_e,
    input  logic              seg_f,
    input  logic              seg_g,
    input  logic              valido,
    output logic              y1,
    output logic              y0,
    output logic [3:0]        saida,
    output logic              ack,
    output logic              erro,
    output logic [CONT_W-1:0] cont_erros,
    output logic [1:0]        estado_dbg
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        FILTRANDO = 2'd1,
        ENTREGUE  = 2'd2
    } estado_t;

    localparam logic [7:0] ALVO = ESTAVEL_CICLOS[7:0];

    estado_t     estado_q;
    logic [6:0]  seg_r_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic [1:0]  codigo_q;
    logic [3:0]  saida_q;
    logic        ack_q;
    logic        erro_q;

    logic [6:0]  padrao;
    logic        legal;
    logic [1:0]  codigo_novo;
    logic        aceitar;

    assign padrao  = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
    assign cnt_inc = cnt_q + 8'd1;

    // Glyph map: only four patterns are legal, everything else is an error.
    always_comb begin
        legal       = 1'b0;
        codigo_novo = 2'b00;
        case (padrao)
            7'b0001100: begin legal = 1'b1; codigo_novo = 2'b00; end
            7'b1111010: begin legal = 1'b1; codigo_novo = 2'b01; end
            7'b1111100: begin legal = 1'b1; codigo_novo = 2'b10; end
            7'b1110011: begin legal = 1'b1; codigo_novo = 2'b11; end
            default:    begin legal = 1'b0; codigo_novo = 2'b00; end
        endcase
    end

    // Accept when the stability target is reached on this edge; with a
    // target of 1 the very first sample in OCIOSO is accepted.
    always_comb begin
        aceitar = 1'b0;
        if (valido) begin
            if (estado_q == OCIOSO && ALVO == 8'd1)
                aceitar = 1'b1;
            else if (estado_q == FILTRANDO && padrao == seg_r_q && cnt_inc == ALVO)
                aceitar = 1'b1;
        end
    end

    // Filter FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            seg_r_q  <= 7'd0;
            cnt_q    <= 8'd0;
            codigo_q <= 2'b00;
            saida_q  <= 4'b0001;
            ack_q    <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (valido) begin
                        seg_r_q  <= padrao;
                        cnt_q    <= 8'd1;
                        estado_q <= aceitar ? ENTREGUE : FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (!valido) begin
                        estado_q <= OCIOSO;
                    end else if (padrao != seg_r_q) begin
                        // Glyph still settling: restart the stability count.
                        seg_r_q <= padrao;
                        cnt_q   <= 8'd1;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (aceitar)
                            estado_q <= ENTREGUE;
                    end
                end
                ENTREGUE: begin
                    if (!valido)
                        estado_q <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase

            if (aceitar) begin
                ack_q <= 1'b1;
                if (legal) begin
                    codigo_q <= codigo_novo;
                    saida_q  <= 4'b0001 << codigo_novo;
                    erro_q   <= 1'b0;
                end else begin
                    erro_q <= 1'b1;
                end
            end
        end
    end

`ifdef CONTADOR_ERROS_EN
    logic [CONT_W-1:0] cont_q;

    // Saturating count of accepted illegal glyphs.
    always_ff @(posedge clk) begin
        if (rst)
            cont_q <= '0;
        else if (aceitar && !legal && cont_q != {CONT_W{1'b1}})
            cont_q <= cont_q + 1'b1;
    end

    assign cont_erros = cont_q;
`else
    assign cont_erros = '0;
`endif

    assign y1         = codigo_q[1];
    assign y0         = codigo_q[0];
    assign saida      = saida_q;
    assign ack        = ack_q;
    assign erro       = erro_q;
    assign estado_dbg = estado_q;

endmodule

// File: tb/tb_decodificador_display.sv
// tb_decodificador_display: directed vectors for decodificador_display.
// Expected deliveries (code, one-hot, erro, cont_erros, ack cycle) are
// queued when a vector is driven; a monitor pops one entry per ack.
module tb_decodificador_display;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int EW = 2 + 4 + 1 + CW + 32;

`ifdef CONTADOR_ERROS_EN
    localparam bit CONT_ON = 1'b1;
`else
    localparam bit CONT_ON = 1'b0;
`endif

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] ENTREGUE = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg = 7'd0;
    logic          valido = 1'b0;
    logic          y1, y0, ack, erro;
    logic [3:0]    saida;
    logic [CW-1:0] cont_erros;
    logic [1:0]    estado_dbg;

    int unsigned ciclo = 0;
    int          checks = 0;
    int          passed = 0;
    int          acks_vistos = 0;
    int          acks_esperados = 0;
    logic        ack_ant = 1'b0;

    logic [EW-1:0] exp_q[$];

    decodificador_display #(.ESTAVEL_CICLOS(N), .CONT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .seg_a(seg[6]), .seg_b(seg[5]), .seg_c(seg[4]), .seg_d(seg[3]),
        .seg_e(seg[2]), .seg_f(seg[1]), .seg_g(seg[0]),
        .valido(valido),
        .y1(y1), .y0(y0), .saida(saida), .ack(ack), .erro(erro),
        .cont_erros(cont_erros), .estado_dbg(estado_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        checks++;
        if (atual === esperado) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, ciclo);
    endtask

    function automatic logic [CW-1:0] cont(input int v);
        return CONT_ON ? CW'(v) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg    = p;
        valido = 1'b1;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        valido = 1'b0;
        repeat (n) tick();
    endtask

    // Expected delivery: ack after edge (ciclo + atraso).
    task automatic espera(input logic [1:0] cod, input logic [3:0] oh, input logic e,
                          input logic [CW-1:0] c, input int atraso);
        int unsigned t;
        t = ciclo + atraso;
        exp_q.push_back({cod, oh, e, c, t});
        acks_esperados++;
    endtask

    task automatic check_saidas(input string nome, input logic [1:0] cod, input logic [3:0] oh,
                                input logic e, input logic [CW-1:0] c);
        check({nome, "_code"},  {y1, y0}, cod);
        check({nome, "_saida"}, saida, oh);
        check({nome, "_erro"},  erro, e);
        check({nome, "_cont"},  cont_erros, c);
    endtask

    // Monitor: every ack must match the oldest expected delivery.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack && ack_ant) check("ack_consecutive", 1, 0);
            if (ack) begin
                acks_vistos++;
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("ack_code",  {y1, y0},   e[EW-1 -: 2]);
                    check("ack_saida", saida,      e[EW-3 -: 4]);
                    check("ack_erro",  erro,       e[EW-7]);
                    check("ack_cont",  cont_erros, e[32 +: CW]);
                    check("ack_cycle", ciclo,      e[31:0]);
                end
            end
        end
        ack_ant = ack;
    end

    initial begin
        // Reset values.
        repeat (2) tick();
        rst = 1'b0;
        check_saidas("reset", 2'b00, 4'b0001, 1'b0, '0);
        check("reset_ack", ack, 0);
        check("reset_state", estado_dbg, OCIOSO);

        // Legal 01 held N samples.
        espera(2'b01, 4'b0010, 1'b0, cont(0), N);
        hold(7'b1111010, N);
        idle(2);

        // Pattern changes after 2 samples: count restarts on the new glyph.
        espera(2'b10, 4'b0100, 1'b0, cont(0), 2 + N);
        hold(7'b1110011, 2);
        hold(7'b1111100, N);
        idle(2);

        // Illegal glyph keeps the code, sets erro, counts once.
        espera(2'b10, 4'b0100, 1'b1, cont(1), N);
        hold(7'b1111111, N);
        idle(2);
        espera(2'b00, 4'b0001, 1'b0, cont(1), N);
        hold(7'b0001100, N);
        idle(2);

        // valido dropped mid-filter: nothing delivered.
        hold(7'b1111010, 2);
        idle(1);
        check("drop_state", estado_dbg, OCIOSO);
        check_saidas("drop", 2'b00, 4'b0001, 1'b0, cont(1));
        idle(2);

        // Glyph switched while valido stays high after ack: ignored.
        espera(2'b11, 4'b1000, 1'b0, cont(1), N);
        hold(7'b1110011, N);
        hold(7'b1111010, 6);
        check("hold_state", estado_dbg, ENTREGUE);
        check_saidas("hold", 2'b11, 4'b1000, 1'b0, cont(1));
        idle(1);
        espera(2'b01, 4'b0010, 1'b0, cont(1), N);
        hold(7'b1111010, N);
        idle(2);

        // Reset in the middle of filtering.
        hold(7'b0001100, 2);
        rst = 1'b1;
        tick();
        check_saidas("midrst", 2'b00, 4'b0001, 1'b0, '0);
        check("midrst_ack", ack, 0);
        check("midrst_state", estado_dbg, OCIOSO);
        rst    = 1'b0;
        valido = 1'b0;
        idle(N + 2);

        // Five illegal glyphs: counter saturates at 3 with CW=2.
        espera(2'b00, 4'b0001, 1'b1, cont(1), N); hold(7'b1111111, N); idle(1);
        espera(2'b00, 4'b0001, 1'b1, cont(2), N); hold(7'b0000000, N); idle(1);
        espera(2'b00, 4'b0001, 1'b1, cont(3), N); hold(7'b1010101, N); idle(1);
        espera(2'b00, 4'b0001, 1'b1, cont(3), N); hold(7'b0001101, N); idle(1);
        espera(2'b00, 4'b0001, 1'b1, cont(3), N); hold(7'b1111011, N); idle(1);
        idle(4);

        check("pending_deliveries", exp_q.size(), 0);
        check("ack_count", acks_vistos, acks_esperados);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/decodificador_display.md
Name: decodificador_display

Overview:
- Receiving end of the priority-code display link: samples the 7-segment pattern driven by the priority encoder and recovers the 2-bit code {y1,y0}.
- Filters the pattern for stability and rejects illegal glyphs.
- Delivers the code, a one-hot equivalent and a one-cycle acknowledge to the downstream actuator logic.

Parameters:
- ESTAVEL_CICLOS, 4, consecutive equal samples required before a pattern is accepted (legal range 1..255).
- CONT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- seg_a..seg_g  input  1 each  received segment lines; pattern order {a,b,c,d,e,f,g}
- valido  input  1  sender asserts while the pattern is meaningful
- y1  output  1  decoded code MSB
- y0  output  1  decoded code LSB
- saida  output  4  one-hot of the code: bit n set for code n
- ack  output  1  one-cycle pulse: new code or error delivered
- erro  output  1  last accepted pattern was illegal
- cont_erros  output  CONT_W  count of illegal patterns accepted

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: y1=0, y0=0, saida=4'b0001, ack=0, erro=0, cont_erros=0, FSM=OCIOSO, stability counter=0, pattern register=0.
- rst wins over every other event. Reset mid-filter discards the pending pattern and emits no ack.
- Legal glyph map, all other 124 patterns illegal:
  - 7'b0001100 -> 00
  - 7'b1111010 -> 01
  - 7'b1111100 -> 10
  - 7'b1110011 -> 11
- FSM states: OCIOSO, FILTRANDO, ENTREGUE.
- OCIOSO: on valido=1, capture pattern into seg_r, set counter=1, go FILTRANDO. If ESTAVEL_CICLOS=1, accept on this same edge and go ENTREGUE.
- FILTRANDO, evaluated in this order each edge:
  - valido=0 -> OCIOSO, no output change, no ack.
  - pattern differs from seg_r -> reload seg_r, set counter=1, stay.
  - Otherwise increment counter. When it reaches ESTAVEL_CICLOS, accept and go ENTREGUE.
- Accept, legal glyph: register y1/y0/saida from the map, clear erro, pulse ack for one cycle.
- Accept, illegal glyph: y1/y0/saida hold previous values, set erro=1, increment cont_erros (saturates at all-ones), pulse ack.
- ENTREGUE: outputs hold. Remain here until valido=0, then OCIOSO. Pattern changes while valido stays high are ignored; the sender must drop valido between codes.
- Latency: if valido rises with pattern P at edge k and P is constant through edge k+ESTAVEL_CICLOS-1, then ack is high in the cycle after that edge and outputs show the new code in that same cycle.
- ack is never high two consecutive cycles.

Optional Feature:
- Macro CONTADOR_ERROS_EN.
- Defined: cont_erros operates as described.
- Undefined: counter logic is not built, cont_erros is tied to 0. erro and the rest of the behaviour are unchanged.

Test Plan:
- Reset, then valido=1 with 7'b1111010 held 4 cycles -> ack single pulse 4 edges after rise; y1=0, y0=1, saida=4'b0010, erro=0.
- Legal 7'b1110011 held, but changed to 7'b1111100 after 2 samples, then held -> ack comes 4 edges after the change; code=10, saida=4'b0100.
- Illegal 7'b1111111 held 4 cycles -> ack pulse, erro=1, cont_erros=1, y1/y0 keep previous code. Then valid 7'b0001100 -> erro=0, code=00, saida=4'b0001.
- valido dropped after 2 samples of a legal pattern -> no ack, outputs unchanged, FSM back in OCIOSO.
- valido held high with pattern switched after ack -> no second ack until valido low then high again.
- rst pulsed during FILTRANDO -> all outputs at reset values next cycle, no ack.
- Macro check, repeated illegal patterns: with CONTADOR_ERROS_EN and CONT_W=2, 5 illegal patterns -> cont_erros saturates at 3. Without the macro -> cont_erros stays 0 while erro still asserts.
